// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: data widths, the EBREAK encoding, the fetch
// FSM state encoding and the {pc, instr} payload carried to decode.
package riscv_pkg;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding one fetched {pc, instr} for decode.
//  clk, reset   : clock, synchronous active-high reset
//  load         : capture load_data and raise out_valid
//  squash       : drop any held word (takes priority over load)
//  load_data    : packet to capture
//  out_ready    : decode consumes when out_valid && out_ready
//  out_valid    : packet held
//  out_data     : held packet (zero after reset)
module fetch_out_reg
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       squash,
    input  fetch_pkt_t load_data,
    input  logic       out_ready,
    output logic       out_valid,
    output fetch_pkt_t out_data
);
    logic       valid_q, valid_d;
    fetch_pkt_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (squash) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory, registers each word with its PC for decode, takes
// branch/jump redirects and stops on EBREAK or on a bad PC.
//  clk, reset          : clock, synchronous active-high reset
//  imem_address/imem_I : memory address (= pc) and same-cycle returned word
//  out_valid/out_ready : handshake to decode; out_instr/out_pc payload
//  redirect/redirect_pc: taken branch/jump and its target
//  halted, fault       : HALT / FAULT state flags
module instruction_fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int unsigned     MEM_BYTES  = 128,
    parameter logic [ILEN-1:0] HALT_INSTR = INSTR_EBREAK
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_address,
    input  logic [ILEN-1:0] imem_I,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            halted,
    output logic            fault
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic            load, squash;
    fetch_pkt_t      load_pkt, out_pkt;

    function automatic logic pc_bad(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || (a >= XLEN'(MEM_BYTES));
    endfunction

    // out_ready only feeds the output register enable; pc_q (hence
    // imem_address) is purely registered.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        load     = 1'b0;
        squash   = 1'b0;
        if (state_q == ST_IDLE) begin
            state_d = ST_FETCH;
        end else if (redirect) begin
            // Redirect beats everything: squash the held word, drop any
            // word arriving this cycle, and re-check the new target.
            squash   = 1'b1;
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            fault_d  = pc_bad(redirect_pc);
            state_d  = pc_bad(redirect_pc) ? ST_FAULT : ST_FETCH;
        end else if (state_q == ST_FETCH) begin
            if (pc_bad(pc_q)) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else if (!out_valid || out_ready) begin
                load = 1'b1;
                pc_d = pc_q + 64'd4;
                // The EBREAK word itself goes to decode; pc stops just past it.
                if (imem_I == HALT_INSTR) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign load_pkt = '{pc: pc_q, instr: imem_I};

    fetch_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .squash    (squash),
        .load_data (load_pkt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_pkt)
    );

    assign imem_address = pc_q;
    assign out_instr    = out_pkt.instr;
    assign out_pc       = out_pkt.pc;
    assign halted       = halted_q;
    assign fault        = fault_q;
endmodule

// File: tb/tb_instruction_fetch_controller.sv
module tb_instruction_fetch_controller;
    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_address;
    logic [31:0] imem_I;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halted;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Memory contents: EBREAK at 0xC, elsewhere 0xA0 tagged with the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'hC) return HALT;
        return {8'hA0, a[23:0]};
    endfunction

    assign imem_I = (imem_address < 64'd128) ? mem_word(imem_address) : 32'h0;

    instruction_fetch_controller #(
        .RESET_PC   (64'h0),
        .MEM_BYTES  (128),
        .HALT_INSTR (HALT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_address (imem_address),
        .imem_I       (imem_I),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halted       (halted),
        .fault        (fault)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] pc);
        exp_q.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    // Monitor: a transfer happens on the coming edge when valid && ready and
    // no redirect squashes it.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got pc %h with empty queue", out_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_pc", out_pc, e.pc);
                    check("xfer_instr", {32'h0, out_instr}, {32'h0, e.instr});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (queue %0d)", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_instr", {32'h0, out_instr}, 64'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_fault", {63'h0, fault}, 64'h0);
        check("rst_addr", imem_address, 64'h0);

        // Sequential fetch, first valid two edges after release
        push(64'h0); push(64'h4);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        check("lat_valid_1", {63'h0, out_valid}, 64'h0);
        tick();
        check("lat_valid_2", {63'h0, out_valid}, 64'h1);
        check("first_pc", out_pc, 64'h0);
        tick();
        check("second_pc", out_pc, 64'h4);

        // Backpressure: hold at out_pc=4, pc frozen at 8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_pc", out_pc, 64'h4);
            check("bp_instr", {32'h0, out_instr}, {32'h0, mem_word(64'h4)});
            check("bp_addr", imem_address, 64'h8);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_pc", out_pc, 64'h8);

        // Redirect to 0x20 squashes the valid word at 0x8
        redirect = 1'b1; redirect_pc = 64'h20;
        tick();
        redirect = 1'b0;
        check("redir_squash", {63'h0, out_valid}, 64'h0);
        check("redir_addr", imem_address, 64'h20);
        push(64'h20);
        tick();
        check("redir_pc", out_pc, 64'h20);
        tick();

        // Redirect to 4, run into EBREAK at 0xC
        push(64'h4); push(64'h8); push(64'hC);
        redirect = 1'b1; redirect_pc = 64'h4;
        tick();
        redirect = 1'b0;
        tick(); tick(); tick();
        check("halt_pc", out_pc, 64'hC);
        check("halt_instr", {32'h0, out_instr}, {32'h0, HALT});
        check("halt_flag", {63'h0, halted}, 64'h1);
        check("halt_addr", imem_address, 64'h10);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halt_novalid", {63'h0, out_valid}, 64'h0);
            check("halt_hold_addr", imem_address, 64'h10);
            check("halt_hold_flag", {63'h0, halted}, 64'h1);
        end

        // Redirect to 0 resumes fetch
        redirect = 1'b1; redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        check("resume_halted", {63'h0, halted}, 64'h0);
        check("resume_addr", imem_address, 64'h0);
        tick();
        check("resume_valid", {63'h0, out_valid}, 64'h1);
        check("resume_pc", out_pc, 64'h0);

        // Misaligned redirect target
        redirect = 1'b1; redirect_pc = 64'h22;
        tick();
        redirect = 1'b0;
        check("mis_fault", {63'h0, fault}, 64'h1);
        check("mis_valid", {63'h0, out_valid}, 64'h0);
        check("mis_addr", imem_address, 64'h22);
        tick();
        check("mis_hold_fault", {63'h0, fault}, 64'h1);
        check("mis_hold_valid", {63'h0, out_valid}, 64'h0);

        // Run off the end of memory
        push(64'h74); push(64'h78); push(64'h7C);
        redirect = 1'b1; redirect_pc = 64'h74;
        tick();
        redirect = 1'b0;
        check("end_fault_clr", {63'h0, fault}, 64'h0);
        tick(); tick(); tick();
        check("end_last_pc", out_pc, 64'h7C);
        check("end_no_fault", {63'h0, fault}, 64'h0);
        tick();
        check("end_fault", {63'h0, fault}, 64'h1);
        check("end_valid", {63'h0, out_valid}, 64'h0);
        check("end_addr", imem_address, 64'h80);

        // Halt with a stalled word, then reset together with a redirect
        push(64'h8);
        redirect = 1'b1; redirect_pc = 64'h8;
        tick();
        redirect = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        check("pre_rst_halted", {63'h0, halted}, 64'h1);
        check("pre_rst_valid", {63'h0, out_valid}, 64'h1);
        check("pre_rst_pc", out_pc, 64'hC);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
        tick();
        check("rst2_valid", {63'h0, out_valid}, 64'h0);
        check("rst2_instr", {32'h0, out_instr}, 64'h0);
        check("rst2_pc", out_pc, 64'h0);
        check("rst2_halted", {63'h0, halted}, 64'h0);
        check("rst2_fault", {63'h0, fault}, 64'h0);
        check("rst2_addr", imem_address, 64'h0);
        reset = 1'b0; redirect = 1'b0;
        tick(); tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
